// File: rtl/spad_frame_config_arbiter.sv
// Two-requester frame-duration arbiter in front of spad_manager: round-robin grant, optional clamp, boundary-gated confirm/timeout.
// Optional feature macro: SPAD_FRAME_CLAMP_EN (clamp accepted durations to [MIN_DUR, MAX_DUR]).

`ifndef MAXIMAL_STATE_DURATION_CLKS_BITS
`define MAXIMAL_STATE_DURATION_CLKS_BITS 16
`endif
`ifndef MINIMAL_FRAME_DURATION_CLKS
`define MINIMAL_FRAME_DURATION_CLKS 1000
`endif

module spad_frame_config_arbiter #(
  parameter int unsigned     DUR_W         = `MAXIMAL_STATE_DURATION_CLKS_BITS,
  parameter longint unsigned MIN_DUR       = `MINIMAL_FRAME_DURATION_CLKS,
  parameter longint unsigned MAX_DUR       = (64'd1 << DUR_W) - 64'd1,
  parameter longint unsigned DEFAULT_DUR   = `MINIMAL_FRAME_DURATION_CLKS,
  parameter int unsigned     TIMEOUT_EDGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Req0Valid,
  input  logic [DUR_W-1:0] Req0Dur,
  output logic             Req0Ready,
  input  logic             Req1Valid,
  input  logic [DUR_W-1:0] Req1Dur,
  output logic             Req1Ready,
  input  logic             FrameDurationChangeEnable,
  input  logic [DUR_W-1:0] FrameDurationCurrentClks,
  output logic [DUR_W-1:0] FrameDurationRequestedClks,
  output logic             Busy,
  output logic             Applied,
  output logic             Timeout,
  output logic             Clamped,
  output logic             LastGrant
);

  localparam int unsigned      L_CW      = (TIMEOUT_EDGES < 2) ? 1 : $clog2(TIMEOUT_EDGES);
  localparam logic [L_CW-1:0]  L_LAST    = L_CW'(TIMEOUT_EDGES - 1);
  localparam logic [DUR_W-1:0] L_DEFAULT = DUR_W'(DEFAULT_DUR);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CONFIRM} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_prio, w_prio_nxt;
  logic [L_CW-1:0]  r_miss, w_miss_nxt;
  logic             r_en_q;
  logic [DUR_W-1:0] r_req, w_req_nxt;
  logic             r_applied, w_applied_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic             r_clamped, w_clamped_nxt;
  logic             r_last_grant, w_grant_nxt;

  logic             w_rdy0, w_rdy1, w_xfer, w_en_rise, w_mod;
  logic [DUR_W-1:0] w_sel, w_dur_c;

  // Ready is gated by reset so requesters see no grant while reset is held.
  always_comb begin
    w_rdy0 = 1'b0;
    w_rdy1 = 1'b0;
    if (reset && (r_state == S_IDLE)) begin
      w_rdy0 = Req0Valid && (!Req1Valid || !r_prio);
      w_rdy1 = Req1Valid && (!Req0Valid ||  r_prio);
    end
  end

  assign w_xfer    = w_rdy0 | w_rdy1;
  assign w_sel     = w_rdy1 ? Req1Dur : Req0Dur;
  assign w_en_rise = FrameDurationChangeEnable && !r_en_q;

`ifdef SPAD_FRAME_CLAMP_EN
  localparam logic [DUR_W-1:0] L_MIN = DUR_W'(MIN_DUR);
  localparam logic [DUR_W-1:0] L_MAX = DUR_W'(MAX_DUR);

  always_comb begin
    w_dur_c = w_sel;
    w_mod   = 1'b0;
    if (w_sel < L_MIN) begin
      w_dur_c = L_MIN;
      w_mod   = 1'b1;
    end else if (w_sel > L_MAX) begin
      w_dur_c = L_MAX;
      w_mod   = 1'b1;
    end
  end
`else
  assign w_dur_c = w_sel;
  assign w_mod   = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_prio_nxt    = r_prio;
    w_miss_nxt    = r_miss;
    w_req_nxt     = r_req;
    w_grant_nxt   = r_last_grant;
    w_applied_nxt = 1'b0;
    w_timeout_nxt = 1'b0;
    w_clamped_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_req_nxt     = w_dur_c;
          w_grant_nxt   = w_rdy1;
          w_prio_nxt    = !r_prio;
          w_clamped_nxt = w_mod;
          if (w_dur_c == FrameDurationCurrentClks) w_applied_nxt = 1'b1;
          else                                     w_state_nxt   = S_ARM;
        end
      end
      S_ARM: begin
        if (w_en_rise) begin
          w_state_nxt = S_CONFIRM;
          w_miss_nxt  = '0;
        end
      end
      S_CONFIRM: begin
        // A match wins over a boundary edge arriving in the same cycle.
        if (FrameDurationCurrentClks == r_req) begin
          w_applied_nxt = 1'b1;
          w_state_nxt   = S_IDLE;
        end else if (w_en_rise) begin
          if (r_miss == L_LAST) begin
            w_timeout_nxt = 1'b1;
            w_state_nxt   = S_IDLE;
            w_miss_nxt    = '0;
          end else begin
            w_miss_nxt = r_miss + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_prio       <= 1'b0;
      r_miss       <= '0;
      r_en_q       <= 1'b0;
      r_req        <= L_DEFAULT;
      r_applied    <= 1'b0;
      r_timeout    <= 1'b0;
      r_clamped    <= 1'b0;
      r_last_grant <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_prio       <= w_prio_nxt;
      r_miss       <= w_miss_nxt;
      r_en_q       <= FrameDurationChangeEnable;
      r_req        <= w_req_nxt;
      r_applied    <= w_applied_nxt;
      r_timeout    <= w_timeout_nxt;
      r_clamped    <= w_clamped_nxt;
      r_last_grant <= w_grant_nxt;
    end
  end

  assign Req0Ready                  = w_rdy0;
  assign Req1Ready                  = w_rdy1;
  assign FrameDurationRequestedClks = r_req;
  assign Busy                       = (r_state != S_IDLE);
  assign Applied                    = r_applied;
  assign Timeout                    = r_timeout;
  assign Clamped                    = r_clamped;
  assign LastGrant                  = r_last_grant;

endmodule

// File: tb/tb_spad_frame_config_arbiter.sv
// Scoreboard bench for spad_frame_config_arbiter: completions (Applied/Timeout) are queued at request time
// and matched against the DUT pulses; works with or without SPAD_FRAME_CLAMP_EN.
module tb_spad_frame_config_arbiter;

  localparam int unsigned W = 16;

  logic         clk, rst_n;
  logic         Req0Valid, Req1Valid;
  logic [W-1:0] Req0Dur, Req1Dur;
  logic         Req0Ready, Req1Ready;
  logic         en;
  logic [W-1:0] cur;
  logic [W-1:0] Requested;
  logic         Busy, Applied, Timeout, Clamped, LastGrant;

  spad_frame_config_arbiter #(
    .DUR_W(W), .MIN_DUR(1000), .MAX_DUR(60000), .DEFAULT_DUR(1000), .TIMEOUT_EDGES(4)
  ) dut (
    .clk(clk), .reset(rst_n),
    .Req0Valid(Req0Valid), .Req0Dur(Req0Dur), .Req0Ready(Req0Ready),
    .Req1Valid(Req1Valid), .Req1Dur(Req1Dur), .Req1Ready(Req1Ready),
    .FrameDurationChangeEnable(en), .FrameDurationCurrentClks(cur),
    .FrameDurationRequestedClks(Requested),
    .Busy(Busy), .Applied(Applied), .Timeout(Timeout), .Clamped(Clamped), .LastGrant(LastGrant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         to;
    logic [W-1:0] dur;
    logic         g;
  } sb_t;

  sb_t sbq[$];
  sb_t e;
  int  n_run  = 0;
  int  n_fail = 0;
  logic prev_to = 1'b0;

  logic [W:0]   ev;
  logic [W-1:0] v;
  logic         cl;
  logic [W-1:0] tbl_dur [3] = '{16'd10, 16'd65000, 16'd0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W:0] exp_val(input logic [W-1:0] d);
`ifdef SPAD_FRAME_CLAMP_EN
    if (d < 16'd1000)  return {1'b1, 16'd1000};
    if (d > 16'd60000) return {1'b1, 16'd60000};
`endif
    return {1'b0, d};
  endfunction

  task automatic sb_push(input logic to, input logic [W-1:0] dur, input logic g);
    sb_t x;
    x.to = to; x.dur = dur; x.g = g;
    sbq.push_back(x);
  endtask

  // Called just after a negedge with request inputs set; returns #1 after the transfer edge.
  task automatic xfer(input logic g, input logic [W-1:0] dur, input logic busy, input logic clmp);
    logic seen = 1'b0;
    #1;
    for (int i = 0; i < 200; i++) begin
      if ((Req0Valid && Req0Ready) || (Req1Valid && Req1Ready)) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    check("xfer_seen", seen, 1);
    check("grant_rdy0", Req0Ready, !g);
    check("grant_rdy1", Req1Ready, g);
    @(posedge clk); #1;
    check("t1_requested", Requested, dur);
    check("t1_lastgrant", LastGrant, g);
    check("t1_busy", Busy, busy);
    check("t1_clamped", Clamped, clmp);
  endtask

  task automatic pulse_en(input int len);
    @(negedge clk); en = 1'b1;
    repeat (len) @(negedge clk);
    en = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sbq.size() == 0) break;
      @(negedge clk); #2;
    end
    check("drain", sbq.size(), 0);
  endtask

  always @(negedge clk) begin
    if (Applied || Timeout) begin
      check("sb_nonempty", sbq.size() != 0, 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("sb_kind", Timeout, e.to);
        check("sb_dur", Requested, e.dur);
        check("sb_grant", LastGrant, e.g);
        check("busy_at_done", Busy, 0);
      end
    end
    if (Timeout) check("timeout_width", prev_to, 0);
    prev_to = Timeout;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0; rst_n = 1'b0; en = 1'b0; cur = 16'd1000;
    Req0Valid = 1'b1; Req0Dur = 16'd5000; Req1Valid = 1'b0; Req1Dur = '0;

    // Reset held with a pending request
    repeat (3) @(negedge clk);
    #1;
    check("rst_requested", Requested, 1000);
    check("rst_rdy0", Req0Ready, 0);
    check("rst_busy", Busy, 0);
    check("rst_applied", Applied, 0);
    check("rst_timeout", Timeout, 0);
    check("rst_clamped", Clamped, 0);
    check("rst_lastgrant", LastGrant, 0);

    // Single request: released from reset, confirmed after a boundary
    @(negedge clk); rst_n = 1'b1;
    sb_push(1'b0, 16'd5000, 1'b0);
    xfer(1'b0, 16'd5000, 1'b1, 1'b0);
    @(negedge clk); Req0Valid = 1'b0;
    repeat (20) @(negedge clk);
    Req1Valid = 1'b1; Req1Dur = 16'd7777;
    #1;
    check("arm_busy", Busy, 1);
    check("arm_rdy1", Req1Ready, 0);
    @(negedge clk); Req1Valid = 1'b0;
    pulse_en(1);
    repeat (3) @(negedge clk);
    cur = 16'd5000;
    wait_drain(20);

    // Contention with fresh priority
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    Req0Valid = 1'b1; Req0Dur = 16'd5001; Req1Valid = 1'b1; Req1Dur = 16'd5002;
    sb_push(1'b0, 16'd5001, 1'b0);
    sb_push(1'b0, 16'd5002, 1'b1);
    sb_push(1'b0, 16'd5004, 1'b0);
    xfer(1'b0, 16'd5001, 1'b1, 1'b0);
    @(negedge clk); Req0Dur = 16'd5004;
    #1;
    check("cont_rdy0_busy", Req0Ready, 0);
    check("cont_rdy1_busy", Req1Ready, 0);
    pulse_en(1);
    repeat (3) @(negedge clk);
    cur = 16'd5001;
    xfer(1'b1, 16'd5002, 1'b1, 1'b0);
    @(negedge clk); Req1Valid = 1'b0;
    pulse_en(1);
    repeat (2) @(negedge clk);
    cur = 16'd5002;
    xfer(1'b0, 16'd5004, 1'b1, 1'b0);
    @(negedge clk); Req0Valid = 1'b0;
    pulse_en(1);
    cur = 16'd5004;
    wait_drain(40);

    // Clamp / pass-through table, alternating requesters
    for (int i = 0; i < 3; i++) begin
      ev = exp_val(tbl_dur[i]);
      v  = ev[W-1:0];
      cl = ev[W];
      @(negedge clk);
      if (i % 2 == 0) begin Req0Valid = 1'b1; Req0Dur = tbl_dur[i]; end
      else            begin Req1Valid = 1'b1; Req1Dur = tbl_dur[i]; end
      sb_push(1'b0, v, (i % 2 == 1));
      xfer((i % 2 == 1), v, 1'b1, cl);
      @(negedge clk); #1;
      check("clamped_width", Clamped, 0);
      Req0Valid = 1'b0; Req1Valid = 1'b0;
      pulse_en(1);
      cur = v;
      wait_drain(20);
    end

    // Timeout: current stuck, first edge arms CONFIRM, four more edges time out
    @(negedge clk); cur = 16'd5000;
    Req0Valid = 1'b1; Req0Dur = 16'd5003;
    sb_push(1'b1, 16'd5003, 1'b0);
    xfer(1'b0, 16'd5003, 1'b1, 1'b0);
    @(negedge clk); Req0Valid = 1'b0;
    pulse_en(1);
    pulse_en(4);
    pulse_en(1);
    pulse_en(1);
    repeat (3) @(negedge clk);
    #2;
    check("to_not_yet", sbq.size(), 1);
    check("to_busy", Busy, 1);
    pulse_en(1);
    #2;
    check("to_exact_edge", sbq.size(), 0);
    @(negedge clk); #1;
    check("to_requested_kept", Requested, 5003);
    check("to_idle", Busy, 0);

    // Same value short-circuit
    @(negedge clk); Req1Valid = 1'b1; Req1Dur = 16'd5000;
    sb_push(1'b0, 16'd5000, 1'b1);
    xfer(1'b1, 16'd5000, 1'b0, 1'b0);
    @(negedge clk); #2;
    check("sc_applied_t1", sbq.size(), 0);
    Req1Valid = 1'b0;

    // Reset while confirming drops the request
    @(negedge clk); Req0Valid = 1'b1; Req0Dur = 16'd5005;
    xfer(1'b0, 16'd5005, 1'b1, 1'b0);
    @(negedge clk); Req0Valid = 1'b0;
    pulse_en(1);
    @(negedge clk); #1;
    check("mid_busy", Busy, 1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("mid_rst_requested", Requested, 1000);
    check("mid_rst_busy", Busy, 0);
    cur = 16'd5005;
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("mid_post_busy", Busy, 0);
    check("mid_post_requested", Requested, 1000);

    check("sb_final", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/spad_frame_config_arbiter.md
# spad_frame_config_arbiter

Arbitrates frame-duration change requests from two requesters (host register path and network control path) and sequences them into `spad_manager`. Drives `FrameDurationRequestedClks` and commits at most one change per accepted request. Waits for a frame boundary (`FrameDurationChangeEnable`), then confirms the change via `FrameDurationCurrentClks`. Sits directly between the control plane and `spad_manager`.

## Interface
- `DUR_W`, `` `MAXIMAL_STATE_DURATION_CLKS_BITS ``, width of all duration values
- `MIN_DUR`, `` `MINIMAL_FRAME_DURATION_CLKS ``, lower clamp bound
- `MAX_DUR`, `2**DUR_W-1`, upper clamp bound
- `DEFAULT_DUR`, `` `MINIMAL_FRAME_DURATION_CLKS ``, reset value of requested duration
- `TIMEOUT_EDGES`, 4, frame-boundary edges tolerated in CONFIRM before giving up
- `clk`  in  1  single clock
- `reset`  in  1  asynchronous, active-low reset
- `Req0Valid` / `Req1Valid`  in  1  requester has a duration pending
- `Req0Dur` / `Req1Dur`  in  DUR_W  requested duration, clks
- `Req0Ready` / `Req1Ready`  out  1  transfer occurs on an edge where Valid && Ready
- `FrameDurationChangeEnable`  in  1  from spad_manager, high at frame boundary
- `FrameDurationCurrentClks`  in  DUR_W  duration currently in effect
- `FrameDurationRequestedClks`  out  DUR_W  to spad_manager
- `Busy`  out  1  state != IDLE
- `Applied`  out  1  one-cycle pulse: change confirmed
- `Timeout`  out  1  one-cycle pulse: change not confirmed
- `Clamped`  out  1  one-cycle pulse: accepted value was clamped
- `LastGrant`  out  1  index of last accepted requester

## Operation
- States: IDLE, ARM, CONFIRM.
- IDLE arbitration (combinational Ready):
  - Sole valid requester is granted.
  - Both valid: the requester with round-robin priority `prio` is granted.
  - `prio` flips to the other requester after every transfer.
  - Ready is 0 in ARM and CONFIRM; requesters hold Valid/Dur until accepted.
- On transfer, the value is clamped to [MIN_DUR, MAX_DUR] (see Configuration) and written to `FrameDurationRequestedClks`. `LastGrant` is updated.
  - If the clamped value == `FrameDurationCurrentClks`: pulse `Applied` next cycle and stay in IDLE.
  - Else: go to ARM.
- ARM: on a rising edge of `FrameDurationChangeEnable` (en && !en_q), go to CONFIRM with `miss_cnt` = 0.
- CONFIRM:
  - If Current == Requested: pulse `Applied`, go to IDLE. This check has priority over the edge count in the same cycle.
  - Each further rising edge of ChangeEnable without a match increments `miss_cnt`.
  - When `miss_cnt` reaches TIMEOUT_EDGES: pulse `Timeout`, go to IDLE. `FrameDurationRequestedClks` is kept.
- ChangeEnable held high continuously counts as one edge.
- Reset (async, any state) values:
  - state=IDLE, `prio`=0, `miss_cnt`=0, en_q=0
  - `FrameDurationRequestedClks`=DEFAULT_DUR
  - `Busy`/`Applied`/`Timeout`/`Clamped`/`LastGrant`=0
  - Ready outputs=0 while reset is asserted
  - An in-flight request is dropped.

## Timing
- Transfer at edge T: Requested, `Clamped`, and `LastGrant` are valid from T+1. `Busy`=1 from T+1 (non-short-circuit case).
- Short-circuit `Applied`: high during T+1 only.
- ChangeEnable edge detection: ChangeEnable sampled high at edge E with en_q=0 → state=CONFIRM from E+1.
- Match detection is registered: Current matching at edge M → `Applied` high during M+1, state=IDLE from M+1. Ready can assert in cycle M+1.
- Minimum request-to-request spacing is 1 cycle (short-circuit case).
- `Applied`, `Timeout`, and `Clamped` never stay high for more than 1 cycle.

## Configuration
- `SPAD_FRAME_CLAMP_EN` defined:
  - Accepted values < MIN_DUR become MIN_DUR; values > MAX_DUR become MAX_DUR.
  - `Clamped` pulses on any modification.
- Undefined:
  - Values pass unmodified, including 0.
  - `Clamped` is tied to 0.

## Test plan
- Reset: hold reset=0 with Req0Valid=1 → Requested=DEFAULT_DUR, Req0Ready=0, `Busy`=0. Release reset → Req0Ready=1 next cycle.
- Single request: MIN_DUR=1000; Req0Dur=5000; ChangeEnable pulse after 20 cycles; Current → 5000 three cycles later → Requested=5000 at T+1, `Applied` exactly once, `Busy` drops the same cycle.
- Contention: both Valid with Dur 5001/5002 → Req0 accepted first, Req1 only after Req0 is `Applied`. Then both again → Req1 wins (round-robin).
- Clamp (macro defined, MIN_DUR=1000, MAX_DUR=60000): request 10 → Requested=1000, `Clamped` pulse. Request 65000 → 60000. Macro undefined: 10 → 10, `Clamped`=0.
- Timeout: request 5003, Current stuck at 5000, 5 ChangeEnable pulses → `Timeout` at the 5th edge (TIMEOUT_EDGES=4 misses after the first), Requested stays 5003, state returns to IDLE.
- Same value / mid-op reset: request equal to Current → `Applied` at T+1 with no ARM. Assert reset while in CONFIRM → IDLE, Requested=DEFAULT_DUR, no `Applied`.
